inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 97 +++++++++
 tb/tb_inst_fetch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: fetch PC, ROM request and a prefetch queue feeding decode.
// Latency: an instruction pushed at edge N is presented after edge N (no bypass).
// Backpressure: stall_i holds the queue head; the ROM is read only while a push can land.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);

  localparam int             AW      = $clog2(QDEPTH);
  localparam logic [AW:0]    CNT_MAX = (AW+1)'(QDEPTH);
  localparam logic [31:0]    PC_INIT = {RESET_PC[31:2], 2'b00};

  logic [31:0]   r_pc;
  logic          r_started;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_q_pc   [QDEPTH];
  logic [31:0]   r_q_inst [QDEPTH];

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_ce;
  logic w_unused_tgt_lsbs;

  // Low target bits are dropped: fetch addresses are always word aligned.
  assign w_unused_tgt_lsbs = &{1'b0, branch_target_i[1:0]};

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CNT_MAX);
  // A redirect suppresses both queue operations.
  assign w_pop   = w_valid & ~stall_i & ~branch_flag_i;
  // Reading while full is allowed only when the head leaves on the same edge.
  assign w_ce    = r_started & (~w_full | w_pop);
  assign w_push  = w_ce & ~branch_flag_i;

  assign rom_ce_o   = w_ce;
  assign rom_addr_o = r_pc;
  assign if_valid_o = w_valid;
  assign if_pc_o    = w_valid ? r_q_pc[r_rd_ptr]   : 32'h0;
  assign if_inst_o  = w_valid ? r_q_inst[r_rd_ptr] : 32'h0;

  // Fetch PC, pointers and occupancy; a redirect flushes and reloads the PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= PC_INIT;
      r_started <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      r_started <= 1'b1;
      if (branch_flag_i) begin
        r_pc     <= {branch_target_i[31:2], 2'b00};
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_pc     <= r_pc + 32'd4;
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + (AW+1)'(1);
        end else if (w_pop && !w_push) begin
          r_count <= r_count - (AW+1)'(1);
        end
      end
    end
  end

  // Queue storage needs no reset; validity comes from count and pointers only.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_pc;
      r_q_inst[r_wr_ptr] <= rom_inst_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = 32'h0;

  logic        ce1, ce2, vld1, vld2;
  logic [31:0] addr1, addr2, inst_in1, inst_in2, pc1, pc2, ins1, ins2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign inst_in1 = ce1 ? rom_word(addr1) : 32'h0;
  assign inst_in2 = ce2 ? rom_word(addr2) : 32'h0;

  inst_fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(br), .branch_target_i(tgt),
    .rom_ce_o(ce1), .rom_addr_o(addr1), .rom_inst_i(inst_in1),
    .if_valid_o(vld1), .if_pc_o(pc1), .if_inst_o(ins1)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(4)) dut_wrap (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(br), .branch_target_i(tgt),
    .rom_ce_o(ce2), .rom_addr_o(addr2), .rom_inst_i(inst_in2),
    .if_valid_o(vld2), .if_pc_o(pc2), .if_inst_o(ins2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Hold reset for two edges, check the reset state, release just after an edge.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; stall = 1'b0; br = 1'b0; tgt = 32'h0;
    @(negedge clk);
    chk("rst_ce", {31'b0, ce1}, 32'h0);
    chk("rst_addr", addr1, 32'h0);
    chk("rst_vld", {31'b0, vld1}, 32'h0);
    chk("rst_pc", pc1, 32'h0);
    chk("rst_inst", ins1, 32'h0);
    chk("rst_addr_wrap", addr2, 32'hFFFF_FFF8);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  typedef struct {
    bit          rst_before;
    bit          stall;
    bit          br;
    logic [31:0] tgt;
    bit          e_ce;
    logic [31:0] e_addr;
    bit          e_vld;
    logic [31:0] e_pc;
    bit          chk2;
    logic [31:0] e_pc2;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, bit b, logic [31:0] t, bit ce,
                              logic [31:0] a, bit v, logic [31:0] p,
                              bit c2, logic [31:0] p2);
    vec_t x;
    x.rst_before = r; x.stall = s; x.br = b; x.tgt = t; x.e_ce = ce;
    x.e_addr = a; x.e_vld = v; x.e_pc = p; x.chk2 = c2; x.e_pc2 = p2;
    return x;
  endfunction

  vec_t tbl[$];

  // Reference model state: queued pcs, fetch pc, first-edge flag.
  logic [31:0] mq[$];
  logic [31:0] mpc;
  bit          mstarted;

  initial begin
    // Free-running fetch, also the wrapping-PC instance.
    tbl.push_back(mk(1,0,0,0, 0,32'h00,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h00,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h04,1,32'h00, 1,32'hFFFF_FFF8));
    tbl.push_back(mk(0,0,0,0, 1,32'h08,1,32'h04, 1,32'hFFFF_FFFC));
    tbl.push_back(mk(0,0,0,0, 1,32'h0C,1,32'h08, 1,32'h0000_0000));
    tbl.push_back(mk(0,0,0,0, 1,32'h10,1,32'h0C, 1,32'h0000_0004));
    tbl.push_back(mk(0,0,0,0, 1,32'h14,1,32'h10, 0,0));
    // Continuous stall: four pushes, freeze, then resume without gaps.
    tbl.push_back(mk(1,1,0,0, 0,32'h00,0,0, 0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h00,0,0, 0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h04,1,32'h00, 0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h08,1,32'h00, 0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h0C,1,32'h00, 0,0));
    tbl.push_back(mk(0,1,0,0, 0,32'h10,1,32'h00, 0,0));
    tbl.push_back(mk(0,1,0,0, 0,32'h10,1,32'h00, 0,0));
    tbl.push_back(mk(0,1,0,0, 0,32'h10,1,32'h00, 0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h10,1,32'h00, 0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h14,1,32'h04, 0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h18,1,32'h08, 0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h1C,1,32'h0C, 0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h20,1,32'h10, 0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h24,1,32'h14, 0,0));
    // Redirect with three entries queued, then back-to-back redirects.
    tbl.push_back(mk(1,1,0,0, 0,32'h00,0,0, 0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h00,0,0, 0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h04,1,32'h00, 0,0));
    tbl.push_back(mk(0,1,0,0, 1,32'h08,1,32'h00, 0,0));
    tbl.push_back(mk(0,1,1,32'h103, 1,32'h0C,1,32'h00, 0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h100,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h104,1,32'h100, 0,0));
    tbl.push_back(mk(0,0,1,32'h208, 1,32'h108,1,32'h104, 0,0));
    tbl.push_back(mk(0,0,1,32'h30C, 1,32'h208,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h30C,0,0, 0,0));
    tbl.push_back(mk(0,0,0,0, 1,32'h310,1,32'h30C, 0,0));

    foreach (tbl[i]) begin
      if (tbl[i].rst_before) do_reset();
      else begin @(posedge clk); #1; end
      stall = tbl[i].stall; br = tbl[i].br; tgt = tbl[i].tgt;
      @(negedge clk);
      chk($sformatf("v%0d_ce", i), {31'b0, ce1}, {31'b0, tbl[i].e_ce});
      chk($sformatf("v%0d_addr", i), addr1, tbl[i].e_addr);
      chk($sformatf("v%0d_vld", i), {31'b0, vld1}, {31'b0, tbl[i].e_vld});
      chk($sformatf("v%0d_pc", i), pc1, tbl[i].e_vld ? tbl[i].e_pc : 32'h0);
      chk($sformatf("v%0d_inst", i), ins1, tbl[i].e_vld ? rom_word(tbl[i].e_pc) : 32'h0);
      if (tbl[i].chk2) begin
        chk($sformatf("v%0d_wrap_vld", i), {31'b0, vld2}, 32'h1);
        chk($sformatf("v%0d_wrap_pc", i), pc2, tbl[i].e_pc2);
        chk($sformatf("v%0d_wrap_inst", i), ins2, rom_word(tbl[i].e_pc2));
      end
    end

    // Redirect while full and stalled, then asynchronous reset pulse with a full queue.
    do_reset();
    stall = 1'b1;
    repeat (7) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("full_ce", {31'b0, ce1}, 32'h0);
    chk("full_addr", addr1, 32'h10);
    @(posedge clk); #1;
    br = 1'b1; tgt = 32'h200;
    @(negedge clk);
    chk("full_br_ce", {31'b0, ce1}, 32'h0);
    @(posedge clk); #1;
    br = 1'b0;
    @(negedge clk);
    chk("after_br_ce", {31'b0, ce1}, 32'h1);
    chk("after_br_addr", addr1, 32'h200);
    chk("after_br_vld", {31'b0, vld1}, 32'h0);
    repeat (6) begin @(posedge clk); #1; end
    chk("refill_pc", pc1, 32'h200);
    chk("refill_ce", {31'b0, ce1}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("arst_vld", {31'b0, vld1}, 32'h0);
    chk("arst_pc", pc1, 32'h0);
    chk("arst_inst", ins1, 32'h0);
    chk("arst_ce", {31'b0, ce1}, 32'h0);
    chk("arst_addr", addr1, 32'h0);
    @(negedge clk);
    rst = 1'b1; stall = 1'b0;
    #1;
    chk("rel_ce", {31'b0, ce1}, 32'h0);
    chk("rel_vld", {31'b0, vld1}, 32'h0);
    @(posedge clk); #1;
    chk("rel2_ce", {31'b0, ce1}, 32'h1);
    chk("rel2_addr", addr1, 32'h0);
    chk("rel2_vld", {31'b0, vld1}, 32'h0);
    @(posedge clk); #1;
    chk("rel3_pc", pc1, 32'h0);
    chk("rel3_inst", ins1, 32'h1000_0000);
    chk("rel3_addr", addr1, 32'h4);
    @(posedge clk); #1;
    chk("rel4_pc", pc1, 32'h4);
    chk("rel4_inst", ins1, 32'h1000_0001);

    // Random stall / redirect against the queue-level model.
    do_reset();
    mq.delete();
    mpc = 32'h0;
    mstarted = 0;
    for (int n = 0; n < 3000; n++) begin
      logic        e_vld, e_ce, e_pop;
      logic [31:0] e_pc;
      stall = ($urandom_range(0, 1) == 1);
      br    = ($urandom_range(0, 99) < 5);
      tgt   = $urandom;
      @(negedge clk);
      e_vld = (mq.size() != 0);
      e_pc  = e_vld ? mq[0] : 32'h0;
      e_pop = e_vld && !stall && !br;
      e_ce  = mstarted && ((mq.size() < 4) || e_pop);
      chk("rnd_ce", {31'b0, ce1}, {31'b0, e_ce});
      chk("rnd_addr", addr1, mpc);
      chk("rnd_vld", {31'b0, vld1}, {31'b0, e_vld});
      chk("rnd_pc", pc1, e_pc);
      chk("rnd_inst", ins1, e_vld ? rom_word(e_pc) : 32'h0);
      if (br) begin
        mq.delete();
        mpc = {tgt[31:2], 2'b00};
      end else begin
        if (e_pop) void'(mq.pop_front());
        if (e_ce) begin
          mq.push_back(mpc);
          mpc = mpc + 32'd4;
        end
      end
      mstarted = 1;
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
